// File: rtl/axis_router_pkg.sv
// -----------------------------------------------------------------------------
// axis_router_pkg
//   Shared definitions for the router's AXI-Stream arbiters.
//   - arb_state_e : packet arbiter state (IDLE = arbitrating, BUSY = packet owned)
//   - rr_pick     : round-robin selection. It scans last+1, last+2, ... modulo
//                   num_ports and returns the first requesting index. If nothing
//                   requests, it returns last unchanged.
// -----------------------------------------------------------------------------
package axis_router_pkg;

    // Upper bound on ports any router arbiter may use. The request vector is
    // passed zero-extended to this width so that one function serves all
    // arbiter sizes.
    localparam int unsigned RR_MAX_PORTS = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // last must be below num_ports, and num_ports must be 2..RR_MAX_PORTS.
    // The wrap uses one conditional subtract rather than a modulo, so the
    // function stays a simple priority chain after elaboration.
    function automatic int unsigned rr_pick(
        input logic [RR_MAX_PORTS-1:0] req,
        input int unsigned             num_ports,
        input int unsigned             last
    );
        int unsigned idx;
        logic        found;
        rr_pick = last;
        found   = 1'b0;
        for (int unsigned k = 1; k <= RR_MAX_PORTS; k++) begin
            idx = last + k;
            if (idx >= num_ports) begin
                idx = idx - num_ports;
            end
            if (!found && (k <= num_ports) && req[idx[4:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// -----------------------------------------------------------------------------
// axis_out_reg
//   Single-entry AXI-Stream output register with valid/ready hold.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset (clears valid/data/last)
//     in_load      : load in_data/in_last this edge (caller guarantees in_free)
//     in_data/last : beat to capture
//     in_free      : register can take a beat this cycle (empty or draining)
//     out_valid/data/last : registered stream outputs
//     out_ready    : downstream ready
// -----------------------------------------------------------------------------
module axis_out_reg
    import axis_router_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_load,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_free,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  last_q,  last_d;

    // Free when empty, or when the held beat leaves on this same edge.
    assign in_free = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (in_load) begin
            valid_d = 1'b1;
            data_d  = in_data;
            last_d  = in_last;
        end else if (valid_q && out_ready) begin
            // Data/last are left as they were; only valid drops.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

endmodule

// File: rtl/axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter
//   Packet-level round-robin arbiter. It merges NUM_PORTS AXI-Stream inputs onto
//   one registered output. A grant is held from a packet's first beat to its
//   TLAST beat, so packets never interleave.
//   Ports:
//     clk, rst                 : clock, synchronous active-high reset
//     s_tdata/s_tvalid/s_tlast : packed per-port input streams
//                                (port i at s_tdata[i*DATA_WIDTH +: DATA_WIDTH])
//     s_tready                 : per-port ready; only the granted port can see 1
//     m_tdata/m_tvalid/m_tlast : registered output stream
//     m_tready                 : downstream ready
//     grant_idx                : granted port; meaningful only while busy
//     busy                     : a packet is currently owned
// -----------------------------------------------------------------------------
module axis_rr_arbiter
    import axis_router_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_PORTS  = 4,
    localparam int IDX_W      = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS-1:0]            s_tvalid,
    input  logic [NUM_PORTS-1:0]            s_tlast,
    output logic [NUM_PORTS-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic                            m_tvalid,
    output logic                            m_tlast,
    input  logic                            m_tready,
    output logic [IDX_W-1:0]                grant_idx,
    output logic                            busy
);

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;

    logic                    out_free;
    logic                    beat_acc;
    logic [DATA_WIDTH-1:0]   port_data [NUM_PORTS];
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_valid;
    logic                    sel_last;
    logic [RR_MAX_PORTS-1:0] req_ext;

    // Unpack inputs. Ready is combinational so that a stalled output register
    // back-pressures the owning port in the same cycle.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign port_data[gi] = s_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign s_tready[gi]  = (state_q == BUSY) && (grant_q == IDX_W'(gi)) && out_free;
    end

    assign sel_data  = port_data[grant_q];
    assign sel_valid = s_tvalid[grant_q];
    assign sel_last  = s_tlast[grant_q];
    assign beat_acc  = (state_q == BUSY) && out_free && sel_valid;
    assign req_ext   = RR_MAX_PORTS'(s_tvalid);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (|s_tvalid) begin
                    grant_d = IDX_W'(rr_pick(req_ext, NUM_PORTS, 32'(last_grant_q)));
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Only the TLAST beat releases the grant. A gap in the owner's
                // valid keeps the grant indefinitely.
                if (beat_acc && sel_last) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Resetting last_grant to the top index makes port 0 the first winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    axis_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .in_load   (beat_acc),
        .in_data   (sel_data),
        .in_last   (sel_last),
        .in_free   (out_free),
        .out_valid (m_tvalid),
        .out_data  (m_tdata),
        .out_last  (m_tlast),
        .out_ready (m_tready)
    );

    assign grant_idx = grant_q;
    assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_rr_arbiter
//   Self-checking bench for axis_rr_arbiter (4 ports x 32 bits).
//   Sources replay per-port beat queues. Every pushed beat also goes into a
//   per-port expected queue. Output beats carry their port number in
//   data[31:24] and are matched in order against that queue. The bench also
//   checks packet contiguity, ready exclusivity and round-robin fairness.
// -----------------------------------------------------------------------------
module tb_axis_rr_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tlast;
    logic [NP-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic [1:0]        grant_idx;
    logic              busy;

    always #5 clk = ~clk;

    axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    // ---------------- bench state ----------------
    logic [32:0] src_q [NP][$];   // {last, data} still to be offered
    logic [32:0] exp_q [NP][$];   // {last, data} still expected on m_*
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          vprob   = 100;
    bit          rand_rdy = 1'b0;
    bit [NP-1:0] vld_r, stall, hs, pend_mask;
    int          in_cnt [NP];
    int          wait_cnt [NP];
    bit          in_first [NP];
    int          out_cnt = 0;
    bit          out_in_pkt;
    int          out_cur;
    int          out_order [$];
    bit          gap_en = 1'b0;
    bit          gap_armed;
    int          last_end_cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            s_tvalid[p] = vld_r[p];
            if (vld_r[p]) begin
                s_tdata[p*DW +: DW] = src_q[p][0][31:0];
                s_tlast[p]          = src_q[p][0][32];
            end else begin
                s_tdata[p*DW +: DW] = '0;
                s_tlast[p]          = 1'b0;
            end
        end
    endtask

    task automatic flush();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
            in_first[p] = 1'b1;
            wait_cnt[p] = 0;
            in_cnt[p]   = 0;
        end
        vld_r      = '0;
        pend_mask  = '0;
        out_in_pkt = 1'b0;
        gap_armed  = 1'b0;
        drive();
    endtask

    task automatic push_pkt(input int p, input int len, input logic [7:0] id);
        logic [32:0] e;
        for (int b = 0; b < len; b++) begin
            e = {(b == len - 1), 8'(p), id, 16'(b)};
            src_q[p].push_back(e);
            exp_q[p].push_back(e);
        end
    endtask

    // One clock: sample at the negedge, then update the sources after the posedge.
    task automatic cycle();
        logic [32:0] e;
        int          port;
        cyc++;
        @(negedge clk);
        check("rdy_onehot", 64'($countones(s_tready) <= 1), 64'(1));
        hs = s_tvalid & s_tready;
        for (int p = 0; p < NP; p++) begin
            if (hs[p]) begin
                in_cnt[p]++;
                if (in_first[p]) begin
                    if (gap_en && gap_armed) check("in_gap", 64'(cyc - last_end_cyc), 64'(2));
                    check("fair_wait", 64'(wait_cnt[p] <= NP - 1), 64'(1));
                    wait_cnt[p] = 0;
                    for (int r = 0; r < NP; r++)
                        if (r != p && pend_mask[r]) wait_cnt[r]++;
                    in_first[p] = 1'b0;
                end
                if (s_tlast[p]) begin
                    in_first[p]  = 1'b1;
                    pend_mask    = s_tvalid & ~(NP'(1) << p);
                    last_end_cyc = cyc;
                    gap_armed    = 1'b1;
                end
            end
        end
        if (m_tvalid && m_tready) begin
            port = int'(m_tdata[31:24]);
            check("out_port_range", 64'(port < NP), 64'(1));
            if (port < NP) begin
                if (out_in_pkt) check("no_interleave", 64'(port), 64'(out_cur));
                else begin
                    out_order.push_back(port);
                    out_cur    = port;
                    out_in_pkt = 1'b1;
                end
                check("beat_expected", 64'(exp_q[port].size() > 0), 64'(1));
                if (exp_q[port].size() > 0) begin
                    e = exp_q[port].pop_front();
                    check("beat", 64'({m_tlast, m_tdata}), 64'(e));
                end
            end
            if (m_tlast) out_in_pkt = 1'b0;
            out_cnt++;
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (hs[p]) begin
                void'(src_q[p].pop_front());
                vld_r[p] = 1'b0;
            end
            if (!vld_r[p] && src_q[p].size() > 0 && !stall[p] && int'($urandom_range(99)) < vprob)
                vld_r[p] = 1'b1;
        end
        drive();
        if (rand_rdy) m_tready = $urandom_range(1);
        #1;
    endtask

    function automatic bit pending();
        bit any = busy || m_tvalid;
        for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) any = 1'b1;
        return any;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (pending() && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 64'(n < budget), 64'(1));
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        flush();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        rst = 1'b1; m_tready = 1'b0; stall = '0;
        s_tvalid = '0; s_tdata = '0; s_tlast = '0;
        flush();
        cycle();
        cycle();
        // Reset state
        check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        check("rst_m_tlast",  64'(m_tlast),  64'(0));
        check("rst_m_tdata",  64'(m_tdata),  64'(0));
        check("rst_busy",     64'(busy),     64'(0));
        check("rst_grant",    64'(grant_idx), 64'(0));
        check("rst_s_tready", 64'(s_tready), 64'(0));
        rst = 1'b0;

        // Port 2, 3-beat packet: latency and busy profile
        m_tready = 1'b1;
        push_pkt(2, 3, 8'hA0);
        cycle();   // valid rises after this edge
        check("t1_busy_e0", 64'(busy), 64'(0));
        cycle();   // arbitration edge
        check("t1_busy_e1", 64'(busy), 64'(1));
        check("t1_grant",   64'(grant_idx), 64'(2));
        check("t1_mvalid_e1", 64'(m_tvalid), 64'(0));
        cycle();   // first beat registered
        check("t1_mvalid_e2", 64'(m_tvalid), 64'(1));
        check("t1_first", 64'({m_tlast, m_tdata}), 64'({1'b0, 32'h02A0_0000}));
        cycle();
        cycle();   // last beat accepted
        check("t1_busy_end", 64'(busy), 64'(0));
        check("t1_last", 64'({m_tlast, m_tdata}), 64'({1'b1, 32'h02A0_0002}));
        drain("t1_drain", 50);

        // All ports offer two 2-beat packets: strict 0,1,2,3 rotation
        apply_reset();
        out_order.delete();
        gap_en = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < NP; p++) push_pkt(p, 2, 8'(k + 1));
        drain("t2_drain", 200);
        gap_en = 1'b0;
        check("t2_npkts", 64'(out_order.size()), 64'(8));
        for (int i = 0; i < out_order.size(); i++) check("t2_order", 64'(out_order[i]), 64'(i % NP));

        // Port 1 with the downstream stalled for 5 cycles mid-packet
        push_pkt(1, 4, 8'h31);
        base = out_cnt; n = 0;
        while (out_cnt == base && n < 20) begin cycle(); n++; end
        check("t3_start", 64'(n < 20), 64'(1));
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t3_hold_valid", 64'(m_tvalid), 64'(1));
            if (exp_q[1].size() > 0) check("t3_hold_beat", 64'({m_tlast, m_tdata}), 64'(exp_q[1][0]));
            check("t3_rdy_low", 64'(s_tready[1]), 64'(0));
        end
        m_tready = 1'b1;
        drain("t3_drain", 50);

        // Port 0 stalls mid-packet while port 3 waits
        out_order.delete();
        push_pkt(0, 4, 8'h40);
        base = in_cnt[0]; n = 0;
        while (in_cnt[0] == base && n < 20) begin cycle(); n++; end
        check("t4_start", 64'(n < 20), 64'(1));
        stall[0] = 1'b1;
        push_pkt(3, 2, 8'h43);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t4_grant", 64'(grant_idx), 64'(0));
            check("t4_busy",  64'(busy), 64'(1));
            check("t4_rdy3",  64'(s_tready[3]), 64'(0));
        end
        stall[0] = 1'b0;
        drain("t4_drain", 60);
        check("t4_npkts", 64'(out_order.size()), 64'(2));
        if (out_order.size() == 2) begin
            check("t4_first",  64'(out_order[0]), 64'(0));
            check("t4_second", 64'(out_order[1]), 64'(3));
        end

        // Reset during beat 2 of a 4-beat packet from port 3
        push_pkt(3, 4, 8'h53);
        base = in_cnt[3]; n = 0;
        while (in_cnt[3] < base + 2 && n < 20) begin cycle(); n++; end
        check("t5_start", 64'(n < 20), 64'(1));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        flush();
        #1;
        check("t5_mvalid", 64'(m_tvalid), 64'(0));
        check("t5_busy",   64'(busy), 64'(0));
        check("t5_rdy",    64'(s_tready), 64'(0));
        out_order.delete();
        push_pkt(1, 2, 8'h61);
        push_pkt(3, 2, 8'h63);
        drain("t5_drain", 60);
        check("t5_npkts", 64'(out_order.size()), 64'(2));
        if (out_order.size() == 2) begin
            check("t5_first",  64'(out_order[0]), 64'(1));
            check("t5_second", 64'(out_order[1]), 64'(3));
        end

        // Random traffic, 50% downstream ready, gappy sources
        rand_rdy = 1'b1;
        vprob    = 80;
        out_order.delete();
        for (int k = 0; k < 20; k++)
            for (int p = 0; p < NP; p++) push_pkt(p, 1 + int'($urandom_range(3)), 8'(k));
        drain("t6_drain", 6000);
        rand_rdy = 1'b0;
        m_tready = 1'b1;
        drain("t6_final", 20);
        check("t6_npkts", 64'(out_order.size()), 64'(20 * NP));
        for (int p = 0; p < NP; p++) check("t6_exp_empty", 64'(exp_q[p].size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares one AXI-Stream router output (typically feeding an output queue) between NUM_PORTS input queues.
- Holds a grant from a packet's first beat to its TLAST beat, so packets never interleave.
- Output is registered: one pipeline stage with a standard valid/ready hold.
- Sits between the per-input queues and the output link of a router port.

Parameters:
- DATA_WIDTH, 32, TDATA width in bits.
- NUM_PORTS, 4, number of requesting input streams; must be at least 2.
- IDX_W, $clog2(NUM_PORTS), width of grant index (derived; not overridden).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset; sampled on posedge clk.
- s_tdata  input  NUM_PORTS*DATA_WIDTH  packed input data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tvalid  input  NUM_PORTS  per-port valid.
- s_tlast  input  NUM_PORTS  per-port end-of-packet.
- s_tready  output  NUM_PORTS  per-port ready.
- m_tdata  output  DATA_WIDTH  output data (registered).
- m_tvalid  output  1  output valid (registered).
- m_tlast  output  1  output end-of-packet (registered).
- m_tready  input  1  downstream ready.
- grant_idx  output  IDX_W  currently granted port; meaningful only when busy=1.
- busy  output  1  high while a packet is owned (state BUSY).

Behaviour:
- Reset values (rst=1 at posedge):
  - state=IDLE, m_tvalid=0, m_tlast=0, m_tdata=0.
  - grant_idx=0, busy=0, s_tready=all 0.
  - last_grant=NUM_PORTS-1, so port 0 has highest priority first.
- Reset asserted mid-packet abandons the packet: output register cleared, the partial packet is not completed, and arbitration restarts from port 0.
- State IDLE:
  - s_tready=0 on all ports.
  - If any s_tvalid is set, select the first asserted port scanning last_grant+1, last_grant+2, … with wrap modulo NUM_PORTS.
  - Load grant_idx with the selected port and go to BUSY on the next edge.
  - If no s_tvalid is set, remain in IDLE.
- State BUSY:
  - out_free = !m_tvalid || m_tready.
  - s_tready[grant_idx] = out_free; all other s_tready=0 (combinational).
- Beat accepted when s_tvalid[grant_idx] && s_tready[grant_idx]:
  - On that edge, load m_tdata, m_tlast and m_tvalid=1 from the granted port.
- Output valid/ready:
  - If m_tvalid && m_tready with no new beat accepted, m_tvalid goes to 0.
  - While m_tvalid && !m_tready, m_tdata and m_tlast are held stable.
- End of packet:
  - Accepted beat with s_tlast=1: next state IDLE, last_grant=grant_idx, busy falls.
  - Granted port deasserting s_tvalid mid-packet does not release the grant; the arbiter waits indefinitely.
- Latency:
  - First beat appears on m_tvalid 2 cycles after s_tvalid rises in IDLE (1 arbitration cycle + 1 register cycle).
  - Steady state: 1 beat/cycle while m_tready=1.
  - Exactly one idle bubble on the input side between consecutive packets (the IDLE arbitration cycle).
  - The output may stay continuously valid across a packet boundary only if the last beat is still held.
- Single-beat packets (s_tlast on the first beat) are legal: BUSY lasts until that beat is accepted.
- Fairness: a port that has valid data is granted within NUM_PORTS-1 packets of other ports.
- Ports not granted never see s_tready=1.
- No data is dropped or duplicated under any m_tready pattern.

Decomposition:
- Shared package (axis_router_pkg): arbiter state enum {IDLE, BUSY}, and a function rr_pick(req, last) returning the next index.
  - The function is also used by other router arbiters.
- One natural sub-module, axis_out_reg: the single-entry output register with valid/ready hold.
  - Arbiter FSM and grant mux stay in the top module.

Test Plan:
- Reset then port 2 sends a 3-beat packet (0xA0, 0xA1, 0xA2 with last), m_tready=1 → grant_idx=2; m_tvalid first high 2 cycles after s_tvalid; beats appear in order; busy drops after the last beat is accepted.
- All 4 ports continuously offer 2-beat packets → grant order 0,1,2,3,0,…; each packet is contiguous on m_*; one input bubble between packets.
- Port 1 granted; m_tready held low for 5 cycles mid-packet → m_tdata and m_tlast stable; s_tready[1]=0 while output full; no beat lost or duplicated after m_tready=1.
- Port 0 granted and stalls s_tvalid for 4 cycles mid-packet while port 3 is valid → grant stays 0 and s_tready[3]=0 throughout; port 3 granted after port 0's last beat.
- rst pulsed for 1 cycle during beat 2 of a 4-beat packet from port 3 → next cycle m_tvalid=0, busy=0, s_tready=0; the next arbitration with ports 1 and 3 requesting picks port 1.
- Randomized m_tready (50%) with random packets on all ports → scoreboard shows per-port in-order delivery, no interleaving, and no port waiting more than 3 packets.
